serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have port ip1  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 SHALL have port ip2  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 SHALL have port sub  input  1  mode select, 1 = A-B, 0 = A+B; captured with operands; present only when SERIAL_ADDER_SUB_EN is defined.
REQ-008 SHALL have port busy  output  1  high while the bit-serial operation runs.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking result valid.
REQ-010 SHALL have port sum  output  WIDTH  result, registered.
REQ-011 SHALL have port carry  output  1  carry-out of MSB (no-borrow flag in subtract mode), registered.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL capture ip1/ip2 (and sub), load carry-in (0 add, 1 sub), clear bit counter, go to RUN.
REQ-014 RUN SHALL process exactly one bit per cycle, LSB first, using one full-adder cell built from two half-adder stages plus OR.
REQ-015 RUN SHALL last exactly WIDTH cycles; counter width $clog2(WIDTH); leave RUN when counter equals WIDTH-1.
REQ-016 DONE SHALL last one cycle, then return to IDLE unconditionally.
REQ-017 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-018 Latency: start accepted at edge k SHALL give busy high in cycles k+1..k+WIDTH and done high in cycle k+WIDTH+1.
REQ-019 sum and carry SHALL update only on entry to DONE and hold until the next DONE; mid-run partial sums SHALL NOT appear on outputs.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH; carry = bit WIDTH of the full (WIDTH+1)-bit result.
REQ-021 start while busy or in DONE SHALL be ignored (no queueing); ip1/ip2/sub changes after capture SHALL NOT affect the running operation.
REQ-022 start held high continuously SHALL start a new operation at each IDLE visit (throughput one result per WIDTH+2 cycles).

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, sum=0, carry=0, counter=0, operand shift registers=0.
REQ-024 Reset asserted during RUN SHALL abort the operation with no done pulse; first start after release SHALL behave as from power-up.
REQ-025 start SHALL be ignored on the first edge coinciding with rst_n deassertion only if rst_n still low at that edge.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN defined: sub port exists; sub=1 inverts ip2 bits as shifted in and sets carry-in 1.
REQ-027 Macro undefined: no sub port; block is add-only, carry-in always 0; all other behaviour identical.

Structure
REQ-028 Shared package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-029 Sub-module fa_cell (a, b, cin -> s, cout) SHALL be instantiated once; it is combinational, composed of two half-adder stages.
REQ-030 Carry between bits SHALL be a single flip-flop; result SHALL assemble in a WIDTH-bit shift register.

Verification (WIDTH=8)
REQ-031 ip1=8'hFF, ip2=8'h01, start at edge k -> busy k+1..k+8, done at k+9, sum=8'h00, carry=1.
REQ-032 ip1=8'h3C, ip2=8'h42 -> sum=8'h7E, carry=0; change ip1 to 8'h00 during RUN -> result unchanged.
REQ-033 SUB_EN build: ip1=8'h05, ip2=8'h07, sub=1 -> sum=8'hFE, carry=0; ip1=8'h07, ip2=8'h05 -> sum=8'h02, carry=1.
REQ-034 Pulse start in cycles k+3 and k+9 of a running op -> ignored, exactly one done; start held high -> done every 10 cycles.
REQ-035 Assert rst_n low at k+4 of an op -> busy/done/sum/carry immediately 0, no done pulse; new op after release correct.
REQ-036 Random ip1/ip2 x 1000 vs reference model {carry,sum} = ip1+ip2 (ip1-ip2 when sub) -> zero mismatches.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational full-adder cell: two half-adder stages whose carries are ORed.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic hs1, hc1, hc2;

  always_comb begin
    hs1  = a ^ b;
    hc1  = a & b;
    s    = hs1 ^ cin;
    hc2  = hs1 & cin;
    cout = hc1 | hc2;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per cycle through a single full-adder cell.
// Define SERIAL_ADDER_SUB_EN to add the sub port (A-B via inverted B and carry-in 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             c_ff;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] b_in;
  logic             cin0;

`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_in = sub ? ~ip2 : ip2;
    cin0 = sub;
  end
`else
  always_comb begin
    b_in = ip2;
    cin0 = 1'b0;
  end
`endif

  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_ff),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      c_ff  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= ip1;
            b_sr <= b_in;
            c_ff <= cin0;
            cnt  <= '0;
            r_sr <= '0;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= {fa_s, r_sr[WIDTH-1:1]};
          c_ff <= fa_c;
          cnt  <= cnt + 1'b1;
          // Final bit goes straight to the outputs so partial sums never appear.
          if (cnt == LAST) begin
            sum   <= {fa_s, r_sr[WIDTH-1:1]};
            carry <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
